// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequential divider:
// state encoding, default width and divide-by-zero result.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic signed [WIDTH_DEF-1:0] DIV0_Q = '1;

endpackage

// File: rtl/alu_div8_if.sv
// START/BUSY/DONE handshake and operand/result bus
// between the control unit and the divider.
interface alu_div8_if
    import alu_pkg::*;
    #(parameter int WIDTH = WIDTH_DEF);

    logic             START;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [WIDTH-1:0] QUOTIENT;
    logic [WIDTH-1:0] REMAINDER;
    logic             BUSY;
    logic             DONE;
    logic             DIV_ZERO;

    modport master (
        output START, DATA1, DATA2,
        input  QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO
    );

    modport slave (
        input  START, DATA1, DATA2,
        output QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO
    );

endinterface

// File: rtl/alu_div8_div_step.sv
// One restoring divide iteration: shift {rem, dvd} left,
// trial-subtract the divisor, shift in the quotient bit.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_nx,
    output logic [WIDTH-1:0] dvd_nx
);

    logic [WIDTH+1:0] diff;
    logic             qbit;

    assign diff   = {rem, dvd[WIDTH-1]} - {2'b00, dvs};
    assign qbit   = ~diff[WIDTH+1];
    assign rem_nx = qbit ? diff[WIDTH:0]
                         : {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign dvd_nx = {dvd[WIDTH-2:0], qbit};

endmodule

// File: rtl/alu_div8.sv
// Signed restoring divider, one quotient bit per clock,
// with sign fix-up and divide-by-zero handling.
module alu_div8
    import alu_pkg::*;
    #(parameter int WIDTH = WIDTH_DEF)
(
    input  logic        CLK,
    input  logic        RESET,
    alu_div8_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last;
    logic             busy;
    logic             done;

    logic             sa;
    logic             sb;
    logic             dz;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] dvd_nx;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dz_r;

    assign accept = bus.START &&
                    (state == ST_IDLE || state == ST_DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .dvd    (dvd),
        .dvs    (dvs),
        .rem_nx (rem_nx),
        .dvd_nx (dvd_nx)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_nx = (bus.DATA2 == '0) ? ST_FIX : ST_RUN;
                else
                    state_nx = ST_IDLE;
            end
            ST_RUN:  if (last) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (1'b1)
            (state == ST_RUN),
            (state == ST_FIX):  busy = 1'b1;
            (state == ST_DONE): done = 1'b1;
            default: ;
        endcase
    end

    // Operands are held as magnitudes; dvd collects quotient bits.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sa   <= 1'b0;
            sb   <= 1'b0;
            dz   <= 1'b0;
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sa   <= bus.DATA1[WIDTH-1];
            sb   <= bus.DATA2[WIDTH-1];
            dz   <= (bus.DATA2 == '0);
            dvd  <= bus.DATA1[WIDTH-1] ? -bus.DATA1 : bus.DATA1;
            dvs  <= bus.DATA2[WIDTH-1] ? -bus.DATA2 : bus.DATA2;
            rem  <= '0;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            rem  <= rem_nx;
            dvd  <= dvd_nx;
            cnt  <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_r  <= '0;
            r_r  <= '0;
            dz_r <= 1'b0;
        end else if (state == ST_FIX) begin
            dz_r <= dz;
            if (dz) begin
                q_r <= WIDTH'(DIV0_Q);
                r_r <= sa ? -dvd : dvd;
            end else begin
                q_r <= (sa ^ sb) ? -dvd : dvd;
                r_r <= sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end
        end
    end

    assign bus.QUOTIENT  = q_r;
    assign bus.REMAINDER = r_r;
    assign bus.DIV_ZERO  = dz_r;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;

endmodule

// File: tb/tb_alu_div8.sv
// Directed self-checking bench for alu_div8.
module tb_alu_div8;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    alu_div8_if #(.WIDTH(8)) bus ();

    alu_div8 #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called #1 after an edge; START is sampled at the next edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        bus.START = 1'b1;
        bus.DATA1 = a;
        bus.DATA2 = b;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.DATA1 = 8'($urandom);
        bus.DATA2 = 8'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit bad);
        lat = 0;
        bad = 1'b0;
        while (!bus.DONE && lat < 40) begin
            if (!bus.BUSY) bad = 1'b1;
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic check_res(input string nm, input int lat,
                             input bit bad, input int xlat,
                             input logic [7:0] q, input logic [7:0] r,
                             input logic dz);
        chk({nm, " latency"}, lat, xlat);
        chk({nm, " busy_gap"}, {31'b0, bad}, 0);
        chk({nm, " busy_in_done"}, {31'b0, bus.BUSY}, 0);
        chk({nm, " quotient"}, {24'b0, bus.QUOTIENT}, {24'b0, q});
        chk({nm, " remainder"}, {24'b0, bus.REMAINDER}, {24'b0, r});
        chk({nm, " div_zero"}, {31'b0, bus.DIV_ZERO}, {31'b0, dz});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  bad;

        tbl[0]  = '{8'd25,   8'd3,    8'd8,    8'd1,    1'b0, 9};
        tbl[1]  = '{8'd5,    8'd0,    8'hFF,   8'd5,    1'b1, 1};
        tbl[2]  = '{8'd6,    8'd3,    8'd2,    8'd0,    1'b0, 9};
        tbl[3]  = '{8'h80,   8'hFF,   8'h80,   8'd0,    1'b0, 9};
        tbl[4]  = '{8'h80,   8'd1,    8'h80,   8'd0,    1'b0, 9};
        tbl[5]  = '{8'd127,  8'h80,   8'd0,    8'd127,  1'b0, 9};
        tbl[6]  = '{8'h80,   8'h80,   8'd1,    8'd0,    1'b0, 9};
        tbl[7]  = '{8'hFF,   8'd127,  8'd0,    8'hFF,   1'b0, 9};
        tbl[8]  = '{8'hFB,   8'd0,    8'hFF,   8'hFB,   1'b1, 1};
        tbl[9]  = '{8'd0,    8'd5,    8'd0,    8'd0,    1'b0, 9};
        tbl[10] = '{8'd100,  8'd7,    8'd14,   8'd2,    1'b0, 9};
        tbl[11] = '{8'h9C,   8'd7,    8'hF2,   8'hFE,   1'b0, 9};

        RESET     = 1'b1;
        bus.START = 1'b0;
        bus.DATA1 = '0;
        bus.DATA2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst quotient", {24'b0, bus.QUOTIENT}, 0);
        chk("rst remainder", {24'b0, bus.REMAINDER}, 0);
        chk("rst busy", {31'b0, bus.BUSY}, 0);
        chk("rst done", {31'b0, bus.DONE}, 0);
        chk("rst div_zero", {31'b0, bus.DIV_ZERO}, 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].a, tbl[i].b);
            wait_done(lat, bad);
            check_res($sformatf("vec%0d", i), lat, bad, tbl[i].lat,
                      tbl[i].q, tbl[i].r, tbl[i].dz);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d done_pulse", i),
                {31'b0, bus.DONE}, 0);
        end

        // Back-to-back sign cases, each START in the DONE cycle.
        issue(8'hF9, 8'd2);
        wait_done(lat, bad);
        check_res("b2b m7_2", lat, bad, 9, 8'hFD, 8'hFF, 1'b0);
        issue(8'd7, 8'hFE);
        wait_done(lat, bad);
        check_res("b2b 7_m2", lat, bad, 9, 8'hFD, 8'h01, 1'b0);
        issue(8'hF9, 8'hFE);
        wait_done(lat, bad);
        check_res("b2b m7_m2", lat, bad, 9, 8'h03, 8'hFF, 1'b0);
        @(posedge CLK);
        #1;
        chk("b2b idle", {30'b0, bus.BUSY, bus.DONE}, 0);

        // START while busy must be ignored.
        issue(8'd50, 8'd5);
        for (int k = 0; k < 3; k++) begin
            bus.START = 1'b1;
            bus.DATA1 = 8'd9;
            bus.DATA2 = 8'd4;
            @(posedge CLK);
            #1;
        end
        bus.START = 1'b0;
        wait_done(lat, bad);
        check_res("ign", lat, bad, 6, 8'd10, 8'd0, 1'b0);
        @(posedge CLK);
        #1;
        chk("ign no_restart", {30'b0, bus.BUSY, bus.DONE}, 0);

        // Asynchronous reset mid-divide.
        issue(8'd100, 8'd7);
        repeat (3) @(posedge CLK);
        #1;
        chk("abort busy_before", {31'b0, bus.BUSY}, 1);
        RESET = 1'b1;
        #1;
        chk("abort quotient", {24'b0, bus.QUOTIENT}, 0);
        chk("abort remainder", {24'b0, bus.REMAINDER}, 0);
        chk("abort busy", {31'b0, bus.BUSY}, 0);
        chk("abort div_zero", {31'b0, bus.DIV_ZERO}, 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            if (k == 2) RESET = 1'b0;
            chk($sformatf("abort no_done%0d", k),
                {31'b0, bus.DONE}, 0);
        end
        issue(8'd100, 8'd7);
        wait_done(lat, bad);
        check_res("after_rst", lat, bad, 9, 8'd14, 8'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
